// File: rtl/apb_slave_module_if.sv
// rtl/apb_slave_module_if.sv - APB bus bundle between a master and the matrix register-file slave
interface apb_slave_module_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int BUS_WIDTH  = 64
);
  logic                   psel_i;
  logic                   penable_i;
  logic                   pwrite_i;
  logic [ADDR_WIDTH-1:0]  paddr_i;
  logic [BUS_WIDTH-1:0]   pwdata_i;
  logic [BUS_WIDTH/8-1:0] pstrb_i;
  logic                   pready_o;
  logic                   pslverr_o;
  logic [BUS_WIDTH-1:0]   prdata_o;

  modport master (
    output psel_i, penable_i, pwrite_i, paddr_i, pwdata_i, pstrb_i,
    input  pready_o, pslverr_o, prdata_o
  );

  modport slave (
    input  psel_i, penable_i, pwrite_i, paddr_i, pwdata_i, pstrb_i,
    output pready_o, pslverr_o, prdata_o
  );
endinterface

// File: rtl/apb_slave_module.sv
// rtl/apb_slave_module.sv - APB slave fronting the matrix register file, with busy stall and timeout
module apb_slave_module #(
  parameter int DATA_WIDTH     = 32,
  parameter int BUS_WIDTH      = 64,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  apb_slave_module_if.slave                  apb,
  input  logic                               busy_i,
  input  logic [BUS_WIDTH-1:0]               rf_data_i,
  output logic [ADDR_WIDTH-1:0]              address_o,
  output logic [BUS_WIDTH-1:0]               data_o,
  output logic [BUS_WIDTH/DATA_WIDTH-1:0]    strobe_o,
  output logic                               write_enable_o,
  output logic                               start_bit_o
);
  localparam int MAX_DIM        = BUS_WIDTH / DATA_WIDTH;
  localparam int BYTES_PER_ELEM = DATA_WIDTH / 8;
  localparam int STRB_W         = BUS_WIDTH / 8;
  localparam int CNT_W          = $clog2(TIMEOUT_CYCLES + 2);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [BUS_WIDTH-1:0]   data_q, data_d;
  logic [STRB_W-1:0]      strb_q, strb_d;
  logic                   write_q, write_d;
  logic                   err_q, err_d;
  logic [CNT_W-1:0]       stall_q, stall_d;
  logic [BUS_WIDTH-1:0]   prdata_q, prdata_d;

  logic [MAX_DIM-1:0]     elem_strb;
  logic                   partial;
  logic [4:0]             offset;
  logic                   is_rw, is_ro, legal;
  logic                   we, start;

  // An element is written only when every one of its bytes is strobed.
  always_comb begin
    elem_strb = '0;
    partial   = 1'b0;
    for (int k = 0; k < MAX_DIM; k++) begin
      elem_strb[k] = &strb_q[k*BYTES_PER_ELEM +: BYTES_PER_ELEM];
      partial      = partial | ((|strb_q[k*BYTES_PER_ELEM +: BYTES_PER_ELEM]) & ~elem_strb[k]);
    end
  end

  assign offset = addr_q[4:0];
  assign is_rw  = (offset == 5'h00) || (offset == 5'h04) || (offset == 5'h0C);
  assign is_ro  = (offset == 5'h08) || (offset == 5'h10);
  assign legal  = write_q ? (is_rw && !partial) : (is_rw || is_ro);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    data_d   = data_q;
    strb_d   = strb_q;
    write_d  = write_q;
    err_d    = err_q;
    stall_d  = stall_q;
    prdata_d = prdata_q;
    we       = 1'b0;
    start    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (apb.psel_i && !apb.penable_i) begin
          addr_d  = apb.paddr_i;
          data_d  = apb.pwdata_i;
          strb_d  = apb.pstrb_i;
          write_d = apb.pwrite_i;
          stall_d = '0;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (!apb.psel_i || !apb.penable_i) begin
          state_d = IDLE;
        end else if (!legal) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else if (!write_q) begin
          prdata_d = rf_data_i;
          err_d    = 1'b0;
          state_d  = DONE;
        end else if (busy_i) begin
          // Counter stops at the limit, so it can never wrap.
          if (stall_q == CNT_W'(TIMEOUT_CYCLES)) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            stall_d = stall_q + CNT_W'(1);
          end
        end else begin
          we      = 1'b1;
          start   = (offset == 5'h00) && data_q[0];
          err_d   = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      data_q   <= '0;
      strb_q   <= '0;
      write_q  <= 1'b0;
      err_q    <= 1'b0;
      stall_q  <= '0;
      prdata_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      strb_q   <= strb_d;
      write_q  <= write_d;
      err_q    <= err_d;
      stall_q  <= stall_d;
      prdata_q <= prdata_d;
    end
  end

  // Reset blanks every output in the same cycle, ahead of any in-flight transfer.
  assign apb.pready_o   = !rst_i && (state_q == DONE);
  assign apb.pslverr_o  = !rst_i && (state_q == DONE) && err_q;
  assign apb.prdata_o   = (rst_i || ((state_q == DONE) && err_q)) ? '0 : prdata_q;
  assign address_o      = rst_i ? '0 : addr_q;
  assign data_o         = rst_i ? '0 : data_q;
  assign write_enable_o = !rst_i && we;
  assign strobe_o       = (!rst_i && we) ? elem_strb : '0;
  assign start_bit_o    = !rst_i && start;
endmodule
